// File: rtl/alu4_pkg.sv
// Shared constants for the 4-bit ALU issue controller: ALU Signal codes, request opcodes,
// FSM state codes and the opcode classifier.
package alu4_pkg;

  localparam int ALU4_WIDTH = 4;

  localparam logic [2:0] SIG_AND = 3'b000;
  localparam logic [2:0] SIG_OR  = 3'b001;
  localparam logic [2:0] SIG_ADD = 3'b010;
  localparam logic [2:0] SIG_SUB = 3'b110;
  localparam logic [2:0] SIG_SLT = 3'b111;

  // Single-cycle opcodes reuse the ALU Signal code directly
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_MUL  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    CLS_SINGLE,
    CLS_MUL,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return CLS_SINGLE;
      OP_MUL:                                return CLS_MUL;
      default:                               return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu4_mul_step.sv
// Shift-add multiplier registers (hi/lo/mcand and a down-counting step timer).
// The ALU performs the add; this block only supplies the addend and shifts the sum in.
module alu4_mul_step #(
  parameter int WIDTH     = 4,
  parameter int MUL_STEPS = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_cout,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     addend,
  output logic [2*WIDTH-1:0]   prod_nxt,
  output logic                 last
);

  localparam int CW = $clog2(MUL_STEPS + 1);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;

  assign addend   = lo[0] ? mcand : '0;
  // The 5-bit ALU sum becomes the new top of the product; lo shifts right by one
  assign prod_nxt = {alu_cout, alu_out, lo[WIDTH-1:1]};
  assign last     = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= b;
      mcand <= a;
      cnt   <= CW'(MUL_STEPS);
    end else if (step) begin
      {hi, lo} <= prod_nxt;
      cnt      <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu4_issue_ctrl.sv
// Sequencing master for the 4-bit ripple ALU: issues single-cycle ops and shift-add MUL,
// returns the result on a valid/ready port. Define ALU4_ISSUE_OVF_EN to add rsp_ovf.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// EXEC  | latched op on the ALU bus, result sampled at the closing edge
// MUL   | one shift-add step per cycle through the ALU adder
// RESP  | rsp_valid high, result held until rsp_ready
module alu4_issue_ctrl
  import alu4_pkg::*;
#(
  parameter int WIDTH     = ALU4_WIDTH,
  parameter int MUL_STEPS = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_cout,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_signal,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_cout
`ifdef ALU4_ISSUE_OVF_EN
  ,
  output logic               rsp_ovf
`endif
);

  state_t           state;
  op_class_e        req_cls;
  logic             accept;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [2:0]       ex_sig;
  logic             ex_cin;

  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_addend;
  logic [2*WIDTH-1:0] mul_prod_nxt;

  assign req_cls   = op_class(req_op);
  assign accept    = (state == ST_IDLE) && req_valid;
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign mul_load  = accept && (req_cls == CLS_MUL);
  assign mul_step  = (state == ST_MUL);

  alu4_mul_step #(
    .WIDTH     (WIDTH),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_load),
    .step     (mul_step),
    .a        (req_a),
    .b        (req_b),
    .alu_out  (alu_out),
    .alu_cout (alu_cout),
    .hi       (mul_hi),
    .addend   (mul_addend),
    .prod_nxt (mul_prod_nxt),
    .last     (mul_last)
  );

  // Outside MUL the bus shows the last latched single-cycle request
  always_comb begin
    alu_a      = ex_a;
    alu_b      = ex_b;
    alu_signal = ex_sig;
    alu_cin    = ex_cin;
    if (state == ST_MUL) begin
      alu_a      = mul_hi;
      alu_b      = mul_addend;
      alu_signal = SIG_ADD;
      alu_cin    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_sig   <= SIG_AND;
      ex_cin   <= 1'b0;
      rsp_data <= '0;
      rsp_cout <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            case (req_cls)
              CLS_SINGLE: begin
                ex_a    <= req_a;
                ex_b    <= req_b;
                ex_sig  <= req_op;
                ex_cin  <= (req_op == OP_SUB) || (req_op == OP_SLT);
                rsp_err <= 1'b0;
                state   <= ST_EXEC;
              end
              CLS_MUL: begin
                rsp_err <= 1'b0;
                state   <= ST_MUL;
              end
              default: begin
                rsp_err  <= 1'b1;
                rsp_data <= '0;
                rsp_cout <= 1'b0;
                state    <= ST_RESP;
              end
            endcase
          end
        end
        ST_EXEC: begin
          rsp_data <= {{WIDTH{1'b0}}, alu_out};
          rsp_cout <= alu_cout;
          state    <= ST_RESP;
        end
        ST_MUL: begin
          if (mul_last) begin
            rsp_data <= mul_prod_nxt;
            rsp_cout <= 1'b0;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU4_ISSUE_OVF_EN
  // Subtraction overflows like an add of the inverted B operand
  logic ovf_sa;
  logic ovf_sb;
  logic ovf_sr;
  logic ovf_arith;

  assign ovf_sa    = ex_a[WIDTH-1];
  assign ovf_sb    = ex_b[WIDTH-1] ^ (ex_sig == SIG_SUB);
  assign ovf_sr    = alu_out[WIDTH-1];
  assign ovf_arith = (ex_sig == SIG_ADD) || (ex_sig == SIG_SUB);

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_ovf <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_ovf <= ovf_arith && (ovf_sa == ovf_sb) && (ovf_sr != ovf_sa);
    end else if (accept) begin
      rsp_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu4_issue_ctrl.sv
// Self-checking bench for alu4_issue_ctrl: a behavioural ALU fixture drives alu_out/alu_cout,
// a cycle-level request/response model predicts every output; directed cases pin literal values.
module tb_alu4_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_cout;
  logic       rsp_err;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_signal;
  logic       alu_cin;
  logic [3:0] alu_out;
  logic       alu_cout;
`ifdef ALU4_ISSUE_OVF_EN
  logic       rsp_ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic cmp_on = 1'b0;
  int n_rsp = 0;

  always #5 clk = ~clk;

  alu4_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cout   (rsp_cout),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_signal (alu_signal),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout)
`ifdef ALU4_ISSUE_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  // Ripple ALU behaviour: adder carry is always reported; SLT is unsigned a<b
  function automatic logic [4:0] alu_fn(input logic [2:0] sig, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
    logic [4:0] s;
    logic [3:0] o;
    s = {1'b0, a} + {1'b0, (sig[2] ? ~b : b)} + {4'b0, cin};
    case (sig)
      3'b000:  o = a & b;
      3'b001:  o = a | b;
      3'b111:  o = {3'b000, ~s[4]};
      default: o = s[3:0];
    endcase
    return {s[4], o};
  endfunction

  assign {alu_cout, alu_out} = alu_fn(alu_signal, alu_a, alu_b, alu_cin);

  function automatic logic ovf_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    if (op == 3'b010) r = sa + sb;
    else if (op == 3'b110) r = sa - sb;
    else return 1'b0;
    return (r > 7) || (r < -8);
  endfunction

  function automatic logic is_single(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110) || (op == 3'b111);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: idle / busy with a cycle countdown / response pending
  logic       m_busy;
  logic       m_valid;
  int         m_cnt;
  logic [7:0] m_data;
  logic       m_cout;
  logic       m_err;
  logic       m_ovf;

  always @(posedge clk) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end else if (req_valid) begin
      m_busy <= 1'b1;
      m_ovf  <= 1'b0;
      if (req_op == 3'b011) begin
        m_data <= 8'(req_a) * 8'(req_b);
        m_cout <= 1'b0;
        m_err  <= 1'b0;
        m_cnt  <= 4;
      end else if (is_single(req_op)) begin
        {m_cout, m_data[3:0]} <= alu_fn(req_op, req_a, req_b, (req_op == 3'b110) || (req_op == 3'b111));
        m_data[7:4] <= 4'h0;
        m_err  <= 1'b0;
        m_ovf  <= ovf_fn(req_op, req_a, req_b);
        m_cnt  <= 1;
      end else begin
        m_data  <= 8'h00;
        m_cout  <= 1'b0;
        m_err   <= 1'b1;
        m_cnt   <= 0;
        m_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("req_ready", req_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_cout", rsp_cout, m_cout);
        chk("rsp_err", rsp_err, m_err);
`ifdef ALU4_ISSUE_OVF_EN
        chk("rsp_ovf", rsp_ovf, m_ovf);
`endif
        if (rsp_ready) n_rsp++;
      end
    end
  end

  logic [7:0] bus_snap;

  task automatic run_op(input string nm, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_data, input logic exp_cout, input logic exp_err,
                        input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    chk({nm, " idle_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        if (is_single(op)) begin
          chk({nm, " bus_signal"}, alu_signal, op);
          chk({nm, " bus_cin"}, alu_cin, op[2]);
          bus_snap = {4'h0, alu_out};
        end else if (op == 3'b011) begin
          chk({nm, " bus_signal"}, alu_signal, 3'b010);
          chk({nm, " bus_cin"}, alu_cin, 0);
          chk({nm, " bus_hi"}, alu_a, 0);
        end
      end
      if (rsp_valid) lat = k;
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " data"}, rsp_data, exp_data);
    chk({nm, " cout"}, rsp_cout, exp_cout);
    chk({nm, " err"}, rsp_err, exp_err);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, " released"}, rsp_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 3'b000;
    req_a = 4'h0;
    req_b = 4'h0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_cout", rsp_cout, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst alu_signal", alu_signal, 3'b000);
    chk("rst alu_cin", alu_cin, 0);
    reset = 1'b0;
    cmp_on = 1'b1;

    run_op("add7_9", 3'b010, 4'd7, 4'd9, 8'h00, 1'b1, 1'b0, 2);
    run_op("sub3_5", 3'b110, 4'd3, 4'd5, 8'h0E, 1'b0, 1'b0, 2);
    run_op("slt3_5", 3'b111, 4'd3, 4'd5, 8'h01, 1'b0, 1'b0, 2);
    chk("slt sampled bus", rsp_data, bus_snap);
    run_op("or5_a", 3'b001, 4'h5, 4'hA, 8'h0F, 1'b0, 1'b0, 2);
    run_op("mul15_15", 3'b011, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 5);
    run_op("mul0_9", 3'b011, 4'd0, 4'd9, 8'h00, 1'b0, 1'b0, 5);
    run_op("mul6_1", 3'b011, 4'd6, 4'd1, 8'h06, 1'b0, 1'b0, 5);
    run_op("illegal100", 3'b100, 4'd3, 4'd4, 8'h00, 1'b0, 1'b1, 1);
    run_op("illegal101", 3'b101, 4'd9, 4'd2, 8'h00, 1'b0, 1'b1, 1);

    // Backpressure with a second request held during busy and during RESP
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b011; req_a = 4'd3; req_b = 4'd5;
    @(negedge clk);
    req_op = 3'b010; req_a = 4'd2; req_b = 4'd3;
    wait_n = 0;
    while (!rsp_valid && wait_n < 20) begin @(negedge clk); wait_n++; end
    chk("bp reached resp", rsp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp req_ready", req_ready, 0);
      chk("bp rsp_valid", rsp_valid, 1);
      chk("bp rsp_data", rsp_data, 8'h0F);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp idle after handshake", req_ready, 1);
    @(negedge clk);
    chk("bp second accepted", req_ready, 0);
    req_valid = 1'b0;
    wait_n = 0;
    while (!rsp_valid && wait_n < 20) begin @(negedge clk); wait_n++; end
    chk("bp second data", rsp_data, 8'h05);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while the multiplier is on its second step
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b011; req_a = 4'd5; req_b = 4'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mulrst req_ready", req_ready, 1);
    chk("mulrst rsp_valid", rsp_valid, 0);
    repeat (6) begin
      @(negedge clk);
      chk("mulrst no rsp", rsp_valid, 0);
    end

    // Randomized traffic, including rsp_ready outside RESP and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 3'($urandom_range(0, 7));
      req_a     = 4'($urandom_range(0, 15));
      req_b     = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    cmp_on = 1'b0;
    $display("random phase responses consumed: %0d", n_rsp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu4_issue_ctrl.md
Name: alu4_issue_ctrl

Overview:
- Sequencing master for the 4-bit ripple ALU datapath in final_cpu.
- Accepts an operation request, drives the ALU operand, Signal and carry-in lines, and captures the ALU result and carry-out.
- Single-cycle ops pass through the ALU once. MUL is an iterative shift-add that uses the ALU's ADD every step.
- Presents the result on a valid/ready response port to the CPU control path.

Parameters:
- WIDTH, 4: ALU operand width; must match the ALU slice count.
- MUL_STEPS, WIDTH: shift-add iterations for MUL.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  3  operation code (package constants)
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- rsp_valid  out  1  result valid; held until accepted
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  2*WIDTH  result; single-cycle ops zero-extended
- rsp_cout  out  1  ALU carry-out of the final ALU pass
- rsp_err  out  1  illegal opcode
- alu_a  out  WIDTH  to ALU dataA
- alu_b  out  WIDTH  to ALU dataB
- alu_signal  out  3  to ALU Signal
- alu_cin  out  1  to ALU cin
- alu_out  in  WIDTH  from ALU dataOut
- alu_cout  in  1  from ALU cout

Behaviour:
- Reset (synchronous, active-high, on the clk edge):
  - State goes to IDLE.
  - req_ready=1 while in IDLE after reset; rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_signal=AND, alu_cin=0.
- ALU Signal encoding:
  - AND=000, OR=001, ADD=010, SUB=110, SLT=111.
  - alu_cin=1 for SUB and SLT; 0 otherwise.
- req_op encoding:
  - AND=000, OR=001, ADD=010, SUB=110, SLT=111, MUL=011.
  - 100 and 101 are illegal.
- FSM states: IDLE, EXEC, MUL, RESP.
  - IDLE: on req_valid&&req_ready, latch op, a and b.
    - Legal single-cycle op goes to EXEC.
    - MUL goes to MUL with hi=0, lo=req_b, mcand=req_a, step=0.
    - Illegal op goes to RESP with rsp_err=1 and rsp_data=0.
  - EXEC: alu_* outputs are registered from the latched request.
    - The ALU combinational result is sampled at the end of EXEC: rsp_data={0,alu_out}, rsp_cout=alu_cout.
    - Goes to RESP.
  - MUL, one step per cycle:
    - alu_a=hi, alu_b=lo[0]?mcand:0, alu_signal=ADD, alu_cin=0.
    - At the edge: {hi,lo} <= {alu_cout,alu_out,lo[WIDTH-1:1]}; step++.
    - After MUL_STEPS steps: rsp_data={hi,lo}, rsp_cout=0, goes to RESP.
  - RESP: rsp_valid=1; rsp_data, rsp_cout and rsp_err are stable. On rsp_ready goes to IDLE and clears rsp_valid.
- Latency from the accept edge to rsp_valid: single-cycle ops 2 cycles; MUL MUL_STEPS+1 cycles; illegal op 1 cycle.
- No new request is accepted until the response is consumed. A req_valid held high during busy is ignored and not lost (req_ready=0).
- rsp_ready asserted outside RESP: ignored.
- Reset mid-MUL or mid-RESP: operation is discarded, no response emitted, and the block returns to IDLE next cycle.
- Arithmetic is unsigned mod 2^WIDTH except MUL, which gives the full 2*WIDTH product.

Optional Feature:
- Macro: ALU4_ISSUE_OVF_EN.
- When defined:
  - Adds output rsp_ovf (1 bit), valid with rsp_valid.
  - ADD/SUB: rsp_ovf = signed overflow, computed from the latched operand MSBs and alu_out[WIDTH-1].
  - Other ops: rsp_ovf = 0.
  - Reset value 0.
- When undefined: port absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu4_pkg holds:
  - ALU Signal constants AND, OR, ADD, SUB, SLT.
  - req_op constants including OP_MUL.
  - FSM state enum.
  - WIDTH default.
- One natural sub-module, alu4_mul_step: the hi/lo/mcand/step registers and shift logic for MUL. It is instantiated once; the FSM owns the alu_* muxing.

Test Plan:
- ADD a=7, b=9 -> rsp_data=0x00, rsp_cout=1, rsp_valid exactly 2 cycles after accept.
- SUB a=3, b=5 -> rsp_data=0x0E, rsp_cout=0. SLT same operands -> alu_signal=111 and alu_cin=1 seen on the bus during EXEC; rsp_data = the ALU output sampled that cycle.
- MUL a=15, b=15 -> rsp_data=0xE1 after 5 cycles; a=0, b=9 -> 0x00; a=6, b=1 -> 0x06.
- Backpressure: rsp_ready low for 4 cycles with a second req_valid high -> rsp fields stable and req_ready=0 throughout; second request accepted only after the handshake.
- Illegal req_op=100 -> rsp_err=1, rsp_data=0, 1-cycle latency. Reset at MUL step 2 -> no rsp_valid, req_ready=1 on the following cycle.
